// File: rtl/nic_host_sched.sv
// Host-side scheduler for one node's NIC register port: polls NIC status and moves
// packets between the host TX/RX streams and the NIC buffers, alternating RX and TX phases.
module nic_host_sched #(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned RD_LAT = 1,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   output logic [1:0]        nic_addr,
   output logic [DATA_W-1:0] nic_di,
   input  logic [DATA_W-1:0] nic_do,
   output logic              nic_en,
   output logic              nic_wren,
   input  logic              tx_valid,
   input  logic [DATA_W-1:0] tx_data,
   output logic              tx_ready,
   output logic              rx_valid,
   output logic [DATA_W-1:0] rx_data,
   input  logic              rx_ready,
   output logic [CNT_W-1:0]  tx_cnt,
   output logic [CNT_W-1:0]  rx_cnt,
   output logic              busy
);

   localparam int unsigned       WAIT_W     = 2;
   localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(RD_LAT - 1);
   localparam logic [1:0]        A_IN_BUF   = 2'b00;
   localparam logic [1:0]        A_IN_STAT  = 2'b01;
   localparam logic [1:0]        A_OUT_BUF  = 2'b10;
   localparam logic [1:0]        A_OUT_STAT = 2'b11;
   localparam logic              TURN_RX    = 1'b0;
   localparam logic              TURN_TX    = 1'b1;

   typedef enum logic [3:0] {
      S_IDLE, S_POLL_IN, S_WAIT_IN, S_RD_IN, S_WAIT_RD,
      S_RX_HOLD, S_POLL_OUT, S_WAIT_OUT, S_WR_OUT
   } state_e;

   state_e              state_q, state_d;
   logic                turn_q, turn_d;
   logic [WAIT_W-1:0]   wait_q, wait_d;
   logic                wait_done;

   logic [1:0]          nic_addr_q, nic_addr_d;
   logic [DATA_W-1:0]   nic_di_q, nic_di_d;
   logic                nic_en_q, nic_en_d;
   logic                nic_wren_q, nic_wren_d;
   logic                tx_ready_q, tx_ready_d;
   logic                rx_valid_q, rx_valid_d;
   logic [DATA_W-1:0]   rx_data_q, rx_data_d;
   logic [CNT_W-1:0]    tx_cnt_q, tx_cnt_d;
   logic [CNT_W-1:0]    rx_cnt_q, rx_cnt_d;
   logic                busy_q, busy_d;

   assign wait_done = (wait_q == WAIT_LAST);

   // State, fairness token and read-latency counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         turn_q  <= TURN_RX;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         turn_q  <= turn_d;
         wait_q  <= wait_d;
      end
   end

   // Next-state: nic_do is sampled only in the last cycle of a WAIT state.
   always_comb begin
      state_d = state_q;
      turn_d  = turn_q;
      wait_d  = '0;
      case (state_q)
         S_IDLE: begin
            if (enable) state_d = (tx_valid && turn_q == TURN_TX) ? S_POLL_OUT : S_POLL_IN;
         end
         S_POLL_IN:  state_d = S_WAIT_IN;
         S_WAIT_IN: begin
            if (!wait_done) begin
               wait_d = wait_q + WAIT_W'(1);
            end else if (nic_do[0]) begin
               state_d = S_RD_IN;
            end else begin
               state_d = S_IDLE;
               turn_d  = TURN_TX;
            end
         end
         S_RD_IN:    state_d = S_WAIT_RD;
         S_WAIT_RD: begin
            if (!wait_done) wait_d = wait_q + WAIT_W'(1);
            else            state_d = S_RX_HOLD;
         end
         S_RX_HOLD: begin
            if (rx_ready) begin
               state_d = S_IDLE;
               turn_d  = TURN_TX;
            end
         end
         S_POLL_OUT: state_d = S_WAIT_OUT;
         S_WAIT_OUT: begin
            if (!wait_done) begin
               wait_d = wait_q + WAIT_W'(1);
            end else if (!nic_do[0] && tx_valid) begin
               state_d = S_WR_OUT;
            end else begin
               state_d = S_IDLE;
               turn_d  = TURN_RX;
            end
         end
         S_WR_OUT: begin
            state_d = S_IDLE;
            turn_d  = TURN_RX;
         end
         default: begin
            state_d = S_IDLE;
            turn_d  = TURN_RX;
         end
      endcase
   end

   // Output next values follow the next state so outputs line up with the state register.
   always_comb begin
      nic_addr_d = '0;
      nic_di_d   = '0;
      nic_en_d   = 1'b0;
      nic_wren_d = 1'b0;
      tx_ready_d = 1'b0;
      rx_valid_d = rx_valid_q;
      rx_data_d  = rx_data_q;
      tx_cnt_d   = tx_cnt_q;
      rx_cnt_d   = rx_cnt_q;
      busy_d     = (state_d != S_IDLE);
      case (state_d)
         S_POLL_IN: begin
            nic_en_d   = 1'b1;
            nic_addr_d = A_IN_STAT;
         end
         S_RD_IN: begin
            nic_en_d   = 1'b1;
            nic_addr_d = A_IN_BUF;
         end
         S_POLL_OUT: begin
            nic_en_d   = 1'b1;
            nic_addr_d = A_OUT_STAT;
         end
         S_WR_OUT: begin
            nic_en_d   = 1'b1;
            nic_wren_d = 1'b1;
            nic_addr_d = A_OUT_BUF;
            nic_di_d   = tx_data;
            tx_ready_d = 1'b1;
         end
         default: ;
      endcase
      if (state_q == S_WAIT_RD && state_d == S_RX_HOLD) begin
         rx_valid_d = 1'b1;
         rx_data_d  = nic_do;
      end
      if (state_q == S_RX_HOLD && state_d == S_IDLE) begin
         rx_valid_d = 1'b0;
         rx_cnt_d   = rx_cnt_q + CNT_W'(1);
      end
      if (state_q == S_WR_OUT) tx_cnt_d = tx_cnt_q + CNT_W'(1);
   end

   // Output registers; reset drops an in-flight access immediately.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         nic_addr_q <= '0;
         nic_di_q   <= '0;
         nic_en_q   <= 1'b0;
         nic_wren_q <= 1'b0;
         tx_ready_q <= 1'b0;
         rx_valid_q <= 1'b0;
         rx_data_q  <= '0;
         tx_cnt_q   <= '0;
         rx_cnt_q   <= '0;
         busy_q     <= 1'b0;
      end else begin
         nic_addr_q <= nic_addr_d;
         nic_di_q   <= nic_di_d;
         nic_en_q   <= nic_en_d;
         nic_wren_q <= nic_wren_d;
         tx_ready_q <= tx_ready_d;
         rx_valid_q <= rx_valid_d;
         rx_data_q  <= rx_data_d;
         tx_cnt_q   <= tx_cnt_d;
         rx_cnt_q   <= rx_cnt_d;
         busy_q     <= busy_d;
      end
   end

   assign nic_addr = nic_addr_q;
   assign nic_di   = nic_di_q;
   assign nic_en   = nic_en_q;
   assign nic_wren = nic_wren_q;
   assign tx_ready = tx_ready_q;
   assign rx_valid = rx_valid_q;
   assign rx_data  = rx_data_q;
   assign tx_cnt   = tx_cnt_q;
   assign rx_cnt   = rx_cnt_q;
   assign busy     = busy_q;

endmodule

// File: doc/nic_host_sched.md
Name: nic_host_sched

Overview:
- Host-side controller that sequences one node's NIC register port (addr / d_in / d_out / nicEN / nicWrEn).
- Shares that single port between a transmit request stream and a receive delivery stream.
- Polls the NIC status registers and moves 64-bit packets between the host streams and the NIC buffers.
- Alternates RX and TX phases so neither direction starves; one instance per node, between node logic and the NIC.

Parameters:
- DATA_W, 64, packet width; equals the NIC buffer width.
- RD_LAT, 1, cycles from a read-command cycle to the cycle nic_do is sampled (1..3).
- CNT_W, 16, width of the packet counters.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  1 = scheduling allowed; 0 = finish current phase, then hold IDLE.
- nic_addr  out  2  NIC register select.
- nic_di  out  DATA_W  write data to NIC d_in.
- nic_do  in  DATA_W  read data from NIC d_out.
- nic_en  out  1  NIC access strobe.
- nic_wren  out  1  1 = write access.
- tx_valid  in  1  host has a packet to send.
- tx_data  in  DATA_W  packet to send.
- tx_ready  out  1  packet accepted this cycle.
- rx_valid  out  1  received packet available.
- rx_data  out  DATA_W  received packet.
- rx_ready  in  1  host takes rx_data this cycle.
- tx_cnt  out  CNT_W  packets written to NIC.
- rx_cnt  out  CNT_W  packets delivered to host.
- busy  out  1  FSM not in IDLE.

Behaviour:
- NIC register map:
  - 00 = input buffer (read).
  - 01 = input status (bit0 = 1 means full).
  - 10 = output buffer (write).
  - 11 = output status (bit0 = 1 means full).
- Every access is exactly one cycle with nic_en=1. nic_en=0 in all other cycles; nic_wren=1 only in WR_OUT.
- Reset (async, reset=0): all outputs 0, FSM=IDLE, turn=RX, counters 0. An in-flight access is aborted immediately (nic_en drops asynchronously). No partial-transfer recovery.
- States: IDLE, POLL_IN, WAIT_IN, RD_IN, WAIT_RD, RX_HOLD, POLL_OUT, WAIT_OUT, WR_OUT.
- IDLE:
  - If enable=0, stay.
  - Else if tx_valid=1 and turn=TX, go to POLL_OUT.
  - Else go to POLL_IN.
- POLL_IN: read addr 01. WAIT_IN lasts RD_LAT cycles; nic_do[0] is sampled in its last cycle.
  - Full: go to RD_IN.
  - Empty: go to IDLE with turn=TX.
- RD_IN: read addr 00. WAIT_RD lasts RD_LAT cycles; capture nic_do into rx_data, set rx_valid=1, go to RX_HOLD.
- RX_HOLD: hold rx_valid and rx_data stable until rx_ready=1.
  - In the rx_ready cycle, clear rx_valid, increment rx_cnt, go to IDLE with turn=TX.
  - The NIC is not accessed during RX_HOLD; backpressure stays in the NIC buffer.
- POLL_OUT: read addr 11. WAIT_OUT lasts RD_LAT cycles.
  - Status full: go to IDLE with turn=RX.
  - Status empty and tx_valid=1: go to WR_OUT.
  - Status empty and tx_valid=0: go to IDLE with turn=RX.
- WR_OUT (one cycle): nic_addr=10, nic_di=tx_data, nic_en=1, nic_wren=1, tx_ready=1. Increment tx_cnt; go to IDLE with turn=RX.
- tx_ready is high only in WR_OUT. The host holds tx_data stable while tx_valid=1 and tx_ready=0.
- Fairness: turn toggles after every completed phase. With continuous traffic both ways, phases alternate RX, TX, RX, …
- When turn=TX and tx_valid=0, RX is polled instead; turn stays TX until a TX phase runs.
- Minimum phase lengths at RD_LAT=1:
  - Empty RX poll: 2 cycles + IDLE.
  - RX transfer: 4 cycles + hold.
  - TX transfer: 3 cycles + IDLE.
- Counters wrap modulo 2^CNT_W with no saturation.
- enable is sampled only in IDLE; deasserting it mid-phase does not abort the phase.
- busy = (state != IDLE), registered with the state.

Test Plan:
- Reset: assert reset=0 mid WR_OUT -> nic_en, nic_wren, tx_ready drop the same cycle; after release all outputs 0, FSM IDLE, first access is a read of addr 01.
- RX single packet: input status bit0=1, buffer=64'hDEAD_BEEF_0123_4567, rx_ready=1 -> rx_valid for 1 cycle with that data, rx_cnt=1, next phase polls addr 11 only if tx_valid=1.
- TX single packet: tx_valid=1, tx_data=64'hA5A5_0000_FFFF_1234, output status empty -> write at addr 10 with that data 3 cycles after leaving IDLE (RD_LAT=1), tx_ready 1 cycle, tx_cnt=1.
- Output full: status 11 bit0=1 for 5 TX phases -> no write, tx_ready never high, RX polls interleave each time, tx_cnt=0.
- Both busy: input always full, rx_ready=1, tx_valid=1, output empty, 10 packets each -> strict RX/TX alternation, tx_cnt=10, rx_cnt=10.
- Backpressure/enable: rx_ready=0 for 20 cycles -> rx_data stable, no NIC access; enable=0 then -> current phase completes, then IDLE with busy=0; RD_LAT=3 run repeats the RX single-packet case with 2 extra wait cycles.
